ysyx_23060208_lsu: RTL and testbench

Parametrised load/store unit that replaces the inline dsram read/write FSMs in the execute stage. It takes one memory request at a time from EXU over a valid/ready handshake and runs it as a single-beat AXI4 master transaction. It handles byte-lane steering, strobe generation, size encoding, sign/zero extension and error reporting for any bus width. It sits between EXU and the intercom/xbar; the `lsu_done` pulse goes to the intercom.

---
 rtl/ysyx_23060208_lsu_pkg.sv | 45 ++++
 rtl/ysyx_23060208_lsu_if.sv | 99 +++++++++
 rtl/ysyx_23060208_lsu_lane.sv | 72 +++++++
 rtl/ysyx_23060208_lsu.sv | 187 ++++++++++++++++++
 tb/tb_ysyx_23060208_lsu.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_23060208_lsu_pkg.sv
// ============================================================================
// Module  : ysyx_23060208_lsu_pkg
// Brief   : Shared types and AXI constants for the load/store unit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ysyx_23060208_lsu_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AR   = 3'd1,
        S_R    = 3'd2,
        S_AW_W = 3'd3,
        S_B    = 3'd4,
        S_RESP = 3'd5
    } lsu_state_e;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] SIZE_D = 2'd3;

    // Doubleword accesses are only legal on a 64-bit core.
    function automatic logic f_misaligned(input logic [2:0] i_addr_lo,
                                          input logic [1:0] i_size,
                                          input logic       i_dw64);
        logic w_bad;
        case (i_size)
            SIZE_B:  w_bad = 1'b0;
            SIZE_H:  w_bad = i_addr_lo[0];
            SIZE_W:  w_bad = |i_addr_lo[1:0];
            default: w_bad = (~i_dw64) | (|i_addr_lo);
        endcase
        return w_bad;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_23060208_lsu_if.sv
// ============================================================================
// Module  : ysyx_23060208_lsu_if
// Brief   : EXU request/response channel plus single-beat AXI4 master bus.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface ysyx_23060208_lsu_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int ADDR_WIDTH     = 32
);
    logic                        req_valid;
    logic                        req_ready;
    logic                        req_wen;
    logic [ADDR_WIDTH-1:0]       req_addr;
    logic [1:0]                  req_size;
    logic                        req_unsigned;
    logic [DATA_WIDTH-1:0]       req_wdata;

    logic                        resp_valid;
    logic                        resp_ready;
    logic [DATA_WIDTH-1:0]       resp_rdata;
    logic                        resp_err;
    logic                        lsu_done;

    logic                        arvalid;
    logic                        arready;
    logic [ADDR_WIDTH-1:0]       araddr;
    logic [3:0]                  arid;
    logic [7:0]                  arlen;
    logic [2:0]                  arsize;
    logic [1:0]                  arburst;

    logic                        rvalid;
    logic                        rready;
    logic [AXI_DATA_WIDTH-1:0]   rdata;
    logic [1:0]                  rresp;
    logic                        rlast;
    logic [3:0]                  rid;

    logic                        awvalid;
    logic                        awready;
    logic [ADDR_WIDTH-1:0]       awaddr;
    logic [3:0]                  awid;
    logic [7:0]                  awlen;
    logic [2:0]                  awsize;
    logic [1:0]                  awburst;

    logic                        wvalid;
    logic                        wready;
    logic [AXI_DATA_WIDTH-1:0]   wdata;
    logic [AXI_DATA_WIDTH/8-1:0] wstrb;
    logic                        wlast;

    logic                        bvalid;
    logic                        bready;
    logic [1:0]                  bresp;
    logic [3:0]                  bid;

    // The LSU side: slave to EXU, master on AXI.
    modport master (
        input  req_valid, req_wen, req_addr, req_size, req_unsigned, req_wdata,
        output req_ready,
        output resp_valid, resp_rdata, resp_err, lsu_done,
        input  resp_ready,
        output arvalid, araddr, arid, arlen, arsize, arburst,
        input  arready,
        input  rvalid, rdata, rresp, rlast, rid,
        output rready,
        output awvalid, awaddr, awid, awlen, awsize, awburst,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bresp, bid,
        output bready
    );

    // The environment side: EXU plus the AXI slave.
    modport slave (
        output req_valid, req_wen, req_addr, req_size, req_unsigned, req_wdata,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_err, lsu_done,
        output resp_ready,
        input  arvalid, araddr, arid, arlen, arsize, arburst,
        output arready,
        output rvalid, rdata, rresp, rlast, rid,
        input  rready,
        input  awvalid, awaddr, awid, awlen, awsize, awburst,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bresp, bid,
        input  bready
    );

endinterface

`default_nettype wire

// File: rtl/ysyx_23060208_lsu_lane.sv
// ============================================================================
// Module  : ysyx_23060208_lsu_lane
// Brief   : Byte-lane steering for stores and extraction/extension for loads.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_23060208_lsu_lane
    import ysyx_23060208_lsu_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int STRB_W         = AXI_DATA_WIDTH / 8,
    parameter int OFF_W          = $clog2(STRB_W)
) (
    input  logic [DATA_WIDTH-1:0]     i_wdata,
    input  logic [1:0]                i_wsize,
    input  logic [OFF_W-1:0]          i_woff,
    output logic [AXI_DATA_WIDTH-1:0] o_wdata,
    output logic [STRB_W-1:0]         o_wstrb,

    input  logic [AXI_DATA_WIDTH-1:0] i_rdata,
    input  logic [1:0]                i_rsize,
    input  logic [OFF_W-1:0]          i_roff,
    input  logic                      i_runsigned,
    output logic [DATA_WIDTH-1:0]     o_rdata
);

    localparam int STRB_EXT_W = STRB_W + 8;

    logic [AXI_DATA_WIDTH-1:0] w_wdata_wide;
    logic [7:0]                w_mask;
    logic [STRB_EXT_W-1:0]     w_strb_wide;
    logic [AXI_DATA_WIDTH-1:0] w_rshift;
    logic [63:0]               w_r64;
    logic [63:0]               w_ext64;

    assign w_wdata_wide = AXI_DATA_WIDTH'(i_wdata);
    assign o_wdata      = w_wdata_wide << {i_woff, 3'b000};

    always_comb begin
        w_mask = 8'h00;
        case (i_wsize)
            SIZE_B:  w_mask = 8'h01;
            SIZE_H:  w_mask = 8'h03;
            SIZE_W:  w_mask = 8'h0F;
            default: w_mask = 8'hFF;
        endcase
    end

    // Strobes pushed past the top lane fall off when truncated.
    assign w_strb_wide = STRB_EXT_W'(w_mask) << i_woff;
    assign o_wstrb     = STRB_W'(w_strb_wide);

    assign w_rshift = i_rdata >> {i_roff, 3'b000};
    assign w_r64    = 64'(w_rshift);

    always_comb begin
        w_ext64 = w_r64;
        case (i_rsize)
            SIZE_B:  w_ext64 = {{56{~i_runsigned & w_r64[7]}},  w_r64[7:0]};
            SIZE_H:  w_ext64 = {{48{~i_runsigned & w_r64[15]}}, w_r64[15:0]};
            SIZE_W:  w_ext64 = {{32{~i_runsigned & w_r64[31]}}, w_r64[31:0]};
            default: w_ext64 = w_r64;
        endcase
    end

    assign o_rdata = DATA_WIDTH'(w_ext64);

endmodule

`default_nettype wire

// File: rtl/ysyx_23060208_lsu.sv
// ============================================================================
// Module  : ysyx_23060208_lsu
// Brief   : Single-outstanding load/store unit, EXU handshake to AXI4 master.
//           Define YSYX_23060208_LSU_MISALIGN_CHECK_EN to reject misaligned
//           accesses without touching the bus.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_23060208_lsu
    import ysyx_23060208_lsu_pkg::*;
#(
    parameter int         DATA_WIDTH     = 32,
    parameter int         AXI_DATA_WIDTH = 64,
    parameter int         ADDR_WIDTH     = 32,
    parameter logic [3:0] AXI_ID         = 4'h1
) (
    input  logic                clock,
    input  logic                reset,
    ysyx_23060208_lsu_if.master bus
);

    localparam int STRB_W = AXI_DATA_WIDTH / 8;
    localparam int OFF_W  = $clog2(STRB_W);

    lsu_state_e                r_state;
    lsu_state_e                w_next;

    logic                      r_active;
    logic [ADDR_WIDTH-1:0]     r_addr;
    logic [1:0]                r_size;
    logic                      r_unsigned;
    logic [AXI_DATA_WIDTH-1:0] r_wdata;
    logic [STRB_W-1:0]         r_wstrb;
    logic                      r_aw_done;
    logic                      r_w_done;
    logic [DATA_WIDTH-1:0]     r_rdata;
    logic                      r_err;
    logic                      r_done;

    logic                      w_accept;
    logic                      w_misalign;
    logic                      w_aw_fire;
    logic                      w_w_fire;
    logic                      w_rd_err;
    logic                      w_wr_err;
    logic [AXI_DATA_WIDTH-1:0] w_wdata_bus;
    logic [STRB_W-1:0]         w_wstrb_bus;
    logic [DATA_WIDTH-1:0]     w_rdata_ext;
    logic                      w_unused;

`ifdef YSYX_23060208_LSU_MISALIGN_CHECK_EN
    assign w_misalign = f_misaligned(bus.req_addr[2:0], bus.req_size, DATA_WIDTH == 64);
`else
    assign w_misalign = 1'b0;
`endif

    ysyx_23060208_lsu_lane #(
        .DATA_WIDTH     (DATA_WIDTH),
        .AXI_DATA_WIDTH (AXI_DATA_WIDTH)
    ) u_lane (
        .i_wdata     (bus.req_wdata),
        .i_wsize     (bus.req_size),
        .i_woff      (bus.req_addr[OFF_W-1:0]),
        .o_wdata     (w_wdata_bus),
        .o_wstrb     (w_wstrb_bus),
        .i_rdata     (bus.rdata),
        .i_rsize     (r_size),
        .i_roff      (r_addr[OFF_W-1:0]),
        .i_runsigned (r_unsigned),
        .o_rdata     (w_rdata_ext)
    );

    // r_active keeps req_ready low for as long as reset is asserted.
    assign w_accept  = (r_state == S_IDLE) && r_active && bus.req_valid;
    assign w_aw_fire = bus.awvalid && bus.awready;
    assign w_w_fire  = bus.wvalid && bus.wready;
    assign w_rd_err  = bus.rresp[1] | (bus.rid != AXI_ID) | ~bus.rlast;
    assign w_wr_err  = bus.bresp[1] | (bus.bid != AXI_ID);
    assign w_unused  = ^{bus.rresp[0], bus.bresp[0]};

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_misalign)       w_next = S_RESP;
                    else if (bus.req_wen) w_next = S_AW_W;
                    else                  w_next = S_AR;
                end
            end
            S_AR:   if (bus.arready) w_next = S_R;
            S_R:    if (bus.rvalid)  w_next = S_RESP;
            S_AW_W: begin
                if ((r_aw_done | w_aw_fire) && (r_w_done | w_w_fire)) w_next = S_B;
            end
            S_B:    if (bus.bvalid)     w_next = S_RESP;
            S_RESP: if (bus.resp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_active   <= 1'b0;
            r_addr     <= '0;
            r_size     <= 2'd0;
            r_unsigned <= 1'b0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_active <= 1'b1;
            r_done   <= (w_next == S_RESP) && (r_state != S_RESP);
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr     <= bus.req_addr;
                        r_size     <= bus.req_size;
                        r_unsigned <= bus.req_unsigned;
                        r_wdata    <= bus.req_wen ? w_wdata_bus : '0;
                        r_wstrb    <= bus.req_wen ? w_wstrb_bus : '0;
                        r_aw_done  <= 1'b0;
                        r_w_done   <= 1'b0;
                        r_rdata    <= '0;
                        r_err      <= w_misalign;
                    end
                end
                S_R: begin
                    if (bus.rvalid) begin
                        r_rdata <= w_rdata_ext;
                        r_err   <= w_rd_err;
                    end
                end
                S_AW_W: begin
                    if (w_aw_fire) r_aw_done <= 1'b1;
                    if (w_w_fire)  r_w_done  <= 1'b1;
                end
                S_B: begin
                    if (bus.bvalid) r_err <= w_wr_err;
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready  = (r_state == S_IDLE) && r_active;
    assign bus.resp_valid = (r_state == S_RESP);
    assign bus.resp_rdata = r_rdata;
    assign bus.resp_err   = r_err;
    assign bus.lsu_done   = r_done;

    assign bus.arvalid = (r_state == S_AR);
    assign bus.araddr  = r_addr;
    assign bus.arid    = AXI_ID;
    assign bus.arlen   = 8'd0;
    assign bus.arsize  = {1'b0, r_size};
    assign bus.arburst = BURST_INCR;
    assign bus.rready  = (r_state == S_R);

    assign bus.awvalid = (r_state == S_AW_W) && !r_aw_done;
    assign bus.awaddr  = r_addr;
    assign bus.awid    = AXI_ID;
    assign bus.awlen   = 8'd0;
    assign bus.awsize  = {1'b0, r_size};
    assign bus.awburst = BURST_INCR;
    assign bus.wvalid  = (r_state == S_AW_W) && !r_w_done;
    assign bus.wdata   = r_wdata;
    assign bus.wstrb   = r_wstrb;
    assign bus.wlast   = 1'b1;
    assign bus.bready  = (r_state == S_B);

endmodule

`default_nettype wire

// File: tb/tb_ysyx_23060208_lsu.sv
// ============================================================================
// Module  : tb_ysyx_23060208_lsu
// Brief   : Scoreboard bench for the LSU with a procedural AXI slave.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ysyx_23060208_lsu;

    localparam int DW  = 32;
    localparam int AXW = 64;
    localparam int ADW = 32;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    ysyx_23060208_lsu_if #(.DATA_WIDTH(DW), .AXI_DATA_WIDTH(AXW), .ADDR_WIDTH(ADW)) bus ();

    ysyx_23060208_lsu #(
        .DATA_WIDTH     (DW),
        .AXI_DATA_WIDTH (AXW),
        .ADDR_WIDTH     (ADW),
        .AXI_ID         (4'h1)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   cyc    = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        cyc++;
    endtask

    function automatic logic [31:0] model_load(input logic [63:0] rd, input logic [31:0] addr,
                                               input logic [1:0] sz, input bit uns);
        int          off = int'(addr[2:0]);
        int          nb  = 1 << sz;
        logic [63:0] v   = '0;
        for (int i = 0; i < nb; i++)
            if (off + i < 8) v[i*8 +: 8] = rd[(off+i)*8 +: 8];
        if (!uns && nb < 8 && v[nb*8-1])
            for (int i = nb * 8; i < 64; i++) v[i] = 1'b1;
        return v[31:0];
    endfunction

    function automatic logic [7:0] model_strb(input logic [31:0] addr, input logic [1:0] sz);
        int         off = int'(addr[2:0]);
        logic [7:0] s   = '0;
        for (int i = 0; i < (1 << sz); i++)
            if (off + i < 8) s[off+i] = 1'b1;
        return s;
    endfunction

    function automatic logic [63:0] model_wdata(input logic [31:0] wd, input logic [31:0] addr);
        logic [63:0] t = {32'h0, wd};
        return t << (8 * int'(addr[2:0]));
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_ready"},  bus.req_ready,  0);
        chk({tag, "_resp_valid"}, bus.resp_valid, 0);
        chk({tag, "_resp_rdata"}, bus.resp_rdata, 0);
        chk({tag, "_resp_err"},   bus.resp_err,   0);
        chk({tag, "_lsu_done"},   bus.lsu_done,   0);
        chk({tag, "_arvalid"},    bus.arvalid,    0);
        chk({tag, "_araddr"},     bus.araddr,     0);
        chk({tag, "_rready"},     bus.rready,     0);
        chk({tag, "_awvalid"},    bus.awvalid,    0);
        chk({tag, "_awaddr"},     bus.awaddr,     0);
        chk({tag, "_wvalid"},     bus.wvalid,     0);
        chk({tag, "_wdata"},      bus.wdata,      0);
        chk({tag, "_wstrb"},      bus.wstrb,      0);
        chk({tag, "_bready"},     bus.bready,     0);
    endtask

    // Drives one request across edge 0; returns at the cycle-1 sample point.
    task automatic t_req(input bit wen, input logic [31:0] addr, input logic [1:0] sz,
                         input bit uns, input logic [31:0] wd);
        chk("req_ready", bus.req_ready, 1);
        bus.req_valid    = 1'b1;
        bus.req_wen      = wen;
        bus.req_addr     = addr;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_wdata    = wd;
        cyc = 0;
        tick();
        bus.req_valid = 1'b0;
        bus.req_addr  = 32'hFFFF_FFFF;
        bus.req_wdata = 32'hDEAD_BEEF;
    endtask

    task automatic t_resp(input int stall, input int exp_lat);
        exp_t e;
        while (!bus.resp_valid && cyc < 40) tick();
        chk("resp_lat", cyc, exp_lat);
        if (sb.size() == 0) begin
            chk("sb_nonempty", 0, 1);
            e = '0;
        end else begin
            e = sb.pop_front();
        end
        chk("resp_rdata", bus.resp_rdata, e.rdata);
        chk("resp_err",   bus.resp_err,   e.err);
        chk("lsu_done",   bus.lsu_done,   1);
        for (int i = 0; i < stall; i++) begin
            tick();
            chk("stall_valid", bus.resp_valid, 1);
            chk("stall_done",  bus.lsu_done,   0);
            chk("stall_rdata", bus.resp_rdata, e.rdata);
            chk("stall_err",   bus.resp_err,   e.err);
        end
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
        chk("resp_drop",  bus.resp_valid, 0);
        chk("back_ready", bus.req_ready,  1);
    endtask

    task automatic run_load(input logic [31:0] addr, input logic [1:0] sz, input bit uns,
                            input logic [63:0] rd, input logic [1:0] rr, input logic [3:0] id,
                            input bit rl, input int ar_wait, input int r_wait,
                            input logic [31:0] exp_rdata, input bit exp_err, input int stall);
        sb.push_back('{exp_rdata, exp_err});
        t_req(1'b0, addr, sz, uns, 32'h0);
        while (!bus.arvalid && cyc < 40) tick();
        chk("arvalid", bus.arvalid, 1);
        chk("araddr",  bus.araddr,  addr);
        chk("arsize",  bus.arsize,  {1'b0, sz});
        chk("arlen",   bus.arlen,   0);
        chk("arburst", bus.arburst, 2'b01);
        chk("arid",    bus.arid,    4'h1);
        for (int i = 0; i < ar_wait; i++) begin
            tick();
            chk("arvalid_hold", bus.arvalid, 1);
        end
        bus.arready = 1'b1;
        tick();
        bus.arready = 1'b0;
        for (int i = 0; i < r_wait; i++) tick();
        chk("rready", bus.rready, 1);
        bus.rvalid = 1'b1;
        bus.rdata  = rd;
        bus.rresp  = rr;
        bus.rid    = id;
        bus.rlast  = rl;
        tick();
        bus.rvalid = 1'b0;
        bus.rdata  = '0;
        t_resp(stall, 3 + ar_wait + r_wait);
    endtask

    task automatic run_store(input logic [31:0] addr, input logic [1:0] sz, input logic [31:0] wd,
                             input logic [1:0] br, input logic [3:0] id,
                             input int aw_wait, input int w_wait,
                             input logic [63:0] exp_wdata, input logic [7:0] exp_wstrb,
                             input bit exp_err, input int stall);
        bit aw_done = 1'b0;
        bit w_done  = 1'b0;
        bit f_aw;
        bit f_w;
        sb.push_back('{32'h0, exp_err});
        t_req(1'b1, addr, sz, 1'b0, wd);
        while (!bus.awvalid && cyc < 40) tick();
        chk("awaddr",  bus.awaddr,  addr);
        chk("awsize",  bus.awsize,  {1'b0, sz});
        chk("awlen",   bus.awlen,   0);
        chk("awburst", bus.awburst, 2'b01);
        chk("awid",    bus.awid,    4'h1);
        chk("wdata",   bus.wdata,   exp_wdata);
        chk("wstrb",   bus.wstrb,   exp_wstrb);
        chk("wlast",   bus.wlast,   1);
        for (int k = 0; k < 20; k++) begin
            bus.awready = (k >= aw_wait);
            bus.wready  = (k >= w_wait);
            chk("awvalid", bus.awvalid, !aw_done);
            chk("wvalid",  bus.wvalid,  !w_done);
            f_aw = bus.awvalid && bus.awready;
            f_w  = bus.wvalid && bus.wready;
            tick();
            aw_done |= f_aw;
            w_done  |= f_w;
            if (aw_done && w_done) break;
        end
        bus.awready = 1'b0;
        bus.wready  = 1'b0;
        chk("aw_w_done", {aw_done, w_done}, 2'b11);
        chk("awvalid_off", bus.awvalid, 0);
        chk("wvalid_off",  bus.wvalid,  0);
        chk("bready", bus.bready, 1);
        bus.bvalid = 1'b1;
        bus.bresp  = br;
        bus.bid    = id;
        tick();
        bus.bvalid = 1'b0;
        chk("bready_once", bus.bready, 0);
        t_resp(stall, 3 + ((aw_wait > w_wait) ? aw_wait : w_wait));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] rd;
        bus.req_valid = 0; bus.req_wen = 0; bus.req_addr = 0; bus.req_size = 0;
        bus.req_unsigned = 0; bus.req_wdata = 0; bus.resp_ready = 0;
        bus.arready = 0; bus.rvalid = 0; bus.rdata = 0; bus.rresp = 0; bus.rlast = 0; bus.rid = 0;
        bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bresp = 0; bus.bid = 0;

        reset = 1'b0;
        repeat (3) tick();
        chk_all_zero("rst");
        reset = 1'b1;
        tick();
        chk("rst_release_ready", bus.req_ready, 1);

        run_load(32'h8000_0003, 2'd0, 1'b0, 64'h0000_0000_8100_0000, 2'b00, 4'h1, 1'b1,
                 0, 0, 32'hFFFF_FF81, 1'b0, 0);
        run_load(32'h8000_0003, 2'd0, 1'b1, 64'h0000_0000_8100_0000, 2'b00, 4'h1, 1'b1,
                 0, 0, 32'h0000_0081, 1'b0, 0);
        rd = 64'h0000_8001_0000_0000;
        run_load(32'h8000_0004, 2'd1, 1'b0, rd, 2'b00, 4'h1, 1'b1, 0, 0,
                 model_load(rd, 32'h8000_0004, 2'd1, 1'b0), 1'b0, 0);
        rd = {$urandom, $urandom};
        run_load(32'h8000_0104, 2'd2, 1'b0, rd, 2'b00, 4'h1, 1'b1, 2, 2,
                 model_load(rd, 32'h8000_0104, 2'd2, 1'b0), 1'b0, 0);
        run_load(32'h8000_0000, 2'd2, 1'b0, 64'h1, 2'b10, 4'h1, 1'b1, 0, 0, 32'h1, 1'b1, 0);
        run_load(32'h8000_0000, 2'd2, 1'b0, 64'h2, 2'b00, 4'h0, 1'b1, 0, 0, 32'h2, 1'b1, 0);
        run_load(32'h8000_0000, 2'd2, 1'b0, 64'h3, 2'b00, 4'h1, 1'b0, 0, 0, 32'h3, 1'b1, 0);

        run_store(32'h8000_0006, 2'd1, 32'h0000_1234, 2'b00, 4'h1, 0, 0,
                  64'h1234_0000_0000_0000, 8'hC0, 1'b0, 0);
        run_store(32'h8000_0001, 2'd0, 32'hAABB_CC5A, 2'b00, 4'h1, 0, 0,
                  model_wdata(32'hAABB_CC5A, 32'h8000_0001), model_strb(32'h8000_0001, 2'd0), 1'b0, 0);
        run_store(32'h8000_0004, 2'd2, 32'hCAFE_F00D, 2'b00, 4'h1, 3, 0,
                  model_wdata(32'hCAFE_F00D, 32'h8000_0004), 8'hF0, 1'b0, 0);
        run_store(32'h8000_0000, 2'd2, 32'h0BAD_CAFE, 2'b00, 4'h1, 0, 2,
                  64'h0000_0000_0BAD_CAFE, 8'h0F, 1'b0, 0);
        run_store(32'h8000_0000, 2'd2, 32'h1, 2'b10, 4'h1, 0, 0, 64'h1, 8'h0F, 1'b1, 0);
        run_store(32'h8000_0000, 2'd2, 32'h2, 2'b00, 4'h3, 0, 0, 64'h2, 8'h0F, 1'b1, 0);

`ifdef YSYX_23060208_LSU_MISALIGN_CHECK_EN
        sb.push_back('{32'h0, 1'b1});
        t_req(1'b0, 32'h8000_0002, 2'd2, 1'b0, 32'h0);
        chk("mis_arvalid", bus.arvalid, 0);
        t_resp(0, 1);
        chk("mis_arvalid_after", bus.arvalid, 0);
        sb.push_back('{32'h0, 1'b1});
        t_req(1'b1, 32'h8000_0007, 2'd1, 1'b0, 32'hABCD);
        chk("mis_awvalid", bus.awvalid, 0);
        chk("mis_wvalid",  bus.wvalid,  0);
        t_resp(0, 1);
        sb.push_back('{32'h0, 1'b1});
        t_req(1'b0, 32'h8000_0000, 2'd3, 1'b0, 32'h0);
        t_resp(0, 1);
`else
        rd = 64'h1122_3344_5566_7788;
        run_load(32'h8000_0002, 2'd2, 1'b0, rd, 2'b00, 4'h1, 1'b1, 0, 0, 32'h3344_5566, 1'b0, 0);
        rd = 64'h8899_AABB_CCDD_EEFF;
        run_load(32'h8000_0006, 2'd2, 1'b0, rd, 2'b00, 4'h1, 1'b1, 0, 0,
                 model_load(rd, 32'h8000_0006, 2'd2, 1'b0), 1'b0, 0);
        run_store(32'h8000_0007, 2'd1, 32'h0000_ABCD, 2'b00, 4'h1, 0, 0,
                  64'hCD00_0000_0000_0000, 8'h80, 1'b0, 0);
`endif

        // Abandon a load while it waits in R.
        t_req(1'b0, 32'h8000_0010, 2'd2, 1'b0, 32'h0);
        while (!bus.arvalid && cyc < 40) tick();
        bus.arready = 1'b1;
        tick();
        bus.arready = 1'b0;
        chk("mid_rready", bus.rready, 1);
        reset      = 1'b0;
        bus.rvalid = 1'b1;
        bus.rdata  = 64'h5555_5555_5555_5555;
        tick();
        chk_all_zero("mid_rst");
        tick();
        chk("mid_rst_rready", bus.rready, 0);
        reset      = 1'b1;
        tick();
        bus.rvalid = 1'b0;
        chk("mid_release_ready", bus.req_ready, 1);
        chk("mid_no_resp", bus.resp_valid, 0);

        rd = 64'h0000_0000_0000_F00F;
        run_load(32'h8000_0020, 2'd1, 1'b1, rd, 2'b00, 4'h1, 1'b1, 0, 0, 32'h0000_F00F, 1'b0, 4);

        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
